// File: rtl/ice_spi_pkg.sv
// Shared types and constants for the ICE SPI bus arbiter and its byte shift engine.
package ice_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int NUM_REQ = 2;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam int TMR_W = 16;

endpackage

// File: rtl/ice_spi_arbiter_shifter.sv
// SPI mode-0 byte engine: H=DIV+1 cycle half periods, 8 bits MSB first.
module spi_byte_shifter
  import ice_spi_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic       setup_end,
  output logic [7:0] rx,
  output logic       sck,
  output logic       mosi
);

  logic [7:0] div_cnt;
  logic [3:0] half;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       tick;

  // half counts completed half periods; boundary half+1 happens on tick
  assign tick      = busy && (div_cnt == 8'(DIV));
  assign done      = tick && (half == 4'd15);
  assign setup_end = tick && (half == 4'd0);
  assign rx        = rx_sr;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      half    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck     <= CPOL;
      mosi    <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      half    <= '0;
      tx_sr   <= tx;
      sck     <= CPOL;
      mosi    <= tx[7];
    end else if (busy) begin
      if (!tick) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        half    <= half + 4'd1;
        if (half[0] == CPHA) begin
          sck   <= ~CPOL;
          rx_sr <= {rx_sr[6:0], miso};
        end else begin
          sck <= CPOL;
          if (half == 4'd15) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
            mosi  <= tx_sr[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ice_spi_arbiter.sv
// Two-requester SPI bus arbiter: round-robin per transaction, CS held across
// multi-byte transactions, idle-hold timeout and a minimum CS gap between owners.
module ice_spi_arbiter
  import ice_spi_pkg::*;
#(
  parameter int DIV     = 3,
  parameter int CS_GAP  = 4,
  parameter int HOLD_TO = 255
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       req0,
  input  logic       last0,
  input  logic [7:0] wdata0,
  output logic       done0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       last1,
  input  logic [7:0] wdata1,
  output logic       done1,
  output logic [7:0] rdata1,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       adc_cs,
  output logic       bme680_cs,
  output logic       busy,
  output logic       owner,
  output logic [2:0] dbg_state
);

  state_t             state, nxt;
  logic               owner_q, rr, last_q;
  logic               done0_q, done1_q;
  logic [7:0]         rdata0_q, rdata1_q;
  logic [TMR_W-1:0]   tmr;
  logic               sel, start, own_req, done_any;
  logic [7:0]         tx;
  logic               sh_busy, sh_done, sh_setup_end;
  logic [7:0]         sh_rx;
  logic [NUM_REQ-1:0] cs_n;

  // Valid/ready: a requester holds req, last and wdata stable until its done
  // pulse; req still high in the cycle after done requests the next byte.
  assign own_req  = owner_q ? req1 : req0;
  assign done_any = done0_q | done1_q;
  assign sel      = (state == ST_IDLE) ? ((req0 && req1) ? rr : req1) : owner_q;
  assign tx       = sel ? wdata1 : wdata0;
  assign start    = (nxt == ST_SETUP) && ((state == ST_IDLE) || (state == ST_HOLD));

  spi_byte_shifter #(.DIV(DIV)) u_shifter (
    .clk       (clk),
    .resetb    (resetb),
    .start     (start),
    .tx        (tx),
    .miso      (miso),
    .busy      (sh_busy),
    .done      (sh_done),
    .setup_end (sh_setup_end),
    .rx        (sh_rx),
    .sck       (sck),
    .mosi      (mosi)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (req0 || req1) nxt = ST_SETUP;
      ST_SETUP:   if (sh_setup_end) nxt = ST_SHIFT;
      ST_SHIFT:   if (sh_done) nxt = last_q ? ST_RELEASE : ST_HOLD;
      // the done cycle itself never counts as a fresh request
      ST_HOLD: begin
        if (own_req && !done_any)              nxt = ST_SETUP;
        else if (tmr == TMR_W'(HOLD_TO - 1))   nxt = ST_RELEASE;
      end
      ST_RELEASE: if (tmr == TMR_W'(CS_GAP - 1)) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q  <= 1'b0;
      rr       <= 1'b0;
      last_q   <= 1'b0;
      tmr      <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (start) begin
        owner_q <= sel;
        last_q  <= sel ? last1 : last0;
      end
      tmr     <= (state != nxt) ? '0 : tmr + 1'b1;
      if ((state == ST_RELEASE) && (nxt == ST_IDLE)) rr <= ~owner_q;
      done0_q <= sh_done && !owner_q;
      done1_q <= sh_done && owner_q;
      if (sh_done && !owner_q) rdata0_q <= sh_rx;
      if (sh_done && owner_q)  rdata1_q <= sh_rx;
    end
  end

  always_comb begin
    cs_n = '1;
    if ((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD)) cs_n[owner_q] = 1'b0;
  end

  assign adc_cs    = cs_n[0];
  assign bme680_cs = cs_n[1];
  assign busy      = (state != ST_IDLE) || sh_busy;
  assign owner     = owner_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ice_spi_arbiter.sv
// Directed bench for ice_spi_arbiter with DIV=1 (H=2), CS_GAP=4, HOLD_TO=10.
module tb_ice_spi_arbiter;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       done0, done1, sck, mosi, adc_cs, bme680_cs, busy, owner;
  logic [7:0] rdata0, rdata1;
  logic [2:0] dbg_state;
  logic       miso = 1'b0;

  logic       miso_mode = 1'b0;
  logic [7:0] miso_pat = '0;
  int         rise_i = 0;
  logic       sck_prev = 1'b0;
  int         n_pass = 0, n_total = 0, viol = 0;

  typedef struct {
    logic       r;
    logic [7:0] wd;
    logic       pat_mode;
    logic [7:0] pat;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  ice_spi_arbiter #(.DIV(1), .CS_GAP(4), .HOLD_TO(10)) dut (
    .clk(clk), .resetb(resetb),
    .req0(req0), .last0(last0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .last1(last1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .sck(sck), .mosi(mosi), .miso(miso),
    .adc_cs(adc_cs), .bme680_cs(bme680_cs), .busy(busy), .owner(owner),
    .dbg_state(dbg_state)
  );

  // slave model: loopback, or a pattern bit valid only while sck is low so a
  // sample taken on the falling edge sees the inverted bit
  always @(negedge clk) begin
    if (adc_cs && bme680_cs) rise_i = 0;
    else if (sck && !sck_prev) rise_i = rise_i + 1;
    sck_prev = sck;
    if (!miso_mode)                 miso = mosi;
    else if (!sck && rise_i < 8)    miso = miso_pat[7 - rise_i];
    else if (sck && rise_i >= 1)    miso = ~miso_pat[8 - rise_i];
    else                            miso = 1'b0;
  end

  always @(negedge clk) begin
    if (resetb) begin
      if (!adc_cs && !bme680_cs) viol = viol + 1;
      if (sck && adc_cs && bme680_cs) viol = viol + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input logic r, input logic v, input logic l, input logic [7:0] d);
    if (r) begin req1 = v; last1 = l; wdata1 = d; end
    else   begin req0 = v; last0 = l; wdata0 = d; end
  endtask

  task automatic wait_cs(input logic r, output int n, output bit ok);
    n = 0; ok = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((r ? bme680_cs : adc_cs) == 1'b0) begin n = i; ok = 1; break; end
    end
  endtask

  task automatic wait_done(input logic r, output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((r ? done1 : done0) == 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic run_single(input vec_t v);
    int n, sck_err, mosi_err, cs_err, busy_err, dcnt, odone;
    bit ok;
    logic own_cs, oth_cs;
    logic [7:0] rx32;
    sck_err = 0; mosi_err = 0; cs_err = 0; busy_err = 0; dcnt = 0; odone = 0; rx32 = '0;
    miso_mode = v.pat_mode;
    miso_pat  = v.pat;
    @(negedge clk);
    set_req(v.r, 1'b1, 1'b1, v.wd);
    wait_cs(v.r, n, ok);
    chk("cs_fall", ok, 1);
    chk("cs_latency", n, 1);
    chk("owner", owner, v.r);
    for (int t = 0; t <= 36; t++) begin
      if (t > 0) @(negedge clk);
      own_cs = v.r ? bme680_cs : adc_cs;
      oth_cs = v.r ? adc_cs : bme680_cs;
      if (sck !== ((t < 32) && (t % 4 >= 2))) sck_err++;
      if (mosi !== ((t < 32) ? v.wd[7 - t / 4] : 1'b0)) mosi_err++;
      if (own_cs !== (t >= 32) || oth_cs !== 1'b1) cs_err++;
      if ((v.r ? done1 : done0) == 1'b1) begin
        dcnt++;
        if (t != 32) odone++;
        rx32 = v.r ? rdata1 : rdata0;
        set_req(v.r, 1'b0, 1'b0, 8'h00);
      end
      if ((v.r ? done0 : done1) == 1'b1) odone++;
      if (t == 35 && busy !== 1'b1) busy_err++;
      if (t == 36 && busy !== 1'b0) busy_err++;
    end
    chk("sck_wave", sck_err, 0);
    chk("mosi_wave", mosi_err, 0);
    chk("cs_wave", cs_err, 0);
    chk("done_count", dcnt, 1);
    chk("done_timing", odone, 0);
    chk("rdata_at_done", rx32, v.exp_rx);
    chk("rdata_held", v.r ? rdata1 : rdata0, v.exp_rx);
    chk("busy_release", busy_err, 0);
  endtask

  task automatic run_both(input logic first, input logic [7:0] d0, input logic [7:0] d1);
    int n;
    bit ok;
    miso_mode = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, d0);
    set_req(1'b1, 1'b1, 1'b1, d1);
    wait_cs(first, n, ok);
    chk("both_first_grant", ok, 1);
    chk("both_first_other_cs", first ? adc_cs : bme680_cs, 1);
    wait_done(first, ok);
    chk("both_first_done", ok, 1);
    chk("both_first_rdata", first ? rdata1 : rdata0, first ? d1 : d0);
    set_req(first, 1'b0, 1'b0, 8'h00);
    wait_cs(~first, n, ok);
    chk("both_gap", n, 5);
    wait_done(~first, ok);
    chk("both_second_done", ok, 1);
    chk("both_second_rdata", first ? rdata0 : rdata1, first ? d0 : d1);
    set_req(~first, 1'b0, 1'b0, 8'h00);
    wait_idle();
  endtask

  initial begin
    logic [7:0] mb[3];
    int n, cs_err, hold_err, extra;
    bit ok;

    vecs[0] = '{r: 1'b0, wd: 8'hA5, pat_mode: 1'b0, pat: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{r: 1'b1, wd: 8'h3C, pat_mode: 1'b0, pat: 8'h00, exp_rx: 8'h3C};
    vecs[2] = '{r: 1'b0, wd: 8'hFF, pat_mode: 1'b1, pat: 8'h3C, exp_rx: 8'h3C};
    vecs[3] = '{r: 1'b1, wd: 8'h00, pat_mode: 1'b1, pat: 8'hFF, exp_rx: 8'hFF};
    vecs[4] = '{r: 1'b0, wd: 8'h96, pat_mode: 1'b1, pat: 8'h69, exp_rx: 8'h69};
    mb[0] = 8'h12; mb[1] = 8'h34; mb[2] = 8'h56;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_pins", {sck, mosi, adc_cs, bme680_cs, busy, owner, done0, done1}, 8'b0011_0000);
    chk("reset_rdata", {rdata0, rdata1}, 16'h0000);
    resetb = 1'b1;

    // simultaneous requests from reset: requester 0 first
    run_both(1'b0, 8'h11, 8'h22);

    for (int i = 0; i < 5; i++) run_single(vecs[i]);

    // last single transfer was requester 0, so requester 1 now wins a tie
    run_both(1'b1, 8'h44, 8'h55);

    // multi-byte stream from requester 1 with requester 0 waiting
    miso_mode = 1'b0;
    cs_err = 0;
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, mb[0]);
    wait_cs(1'b1, n, ok);
    chk("multi_cs_fall", ok, 1);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      ok = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (done1) begin ok = 1; break; end
        if (bme680_cs !== 1'b0 || adc_cs !== 1'b1) cs_err++;
      end
      chk("multi_done", ok, 1);
      chk("multi_rdata", rdata1, mb[i]);
      if (i < 2) begin
        if (bme680_cs !== 1'b0) cs_err++;
        set_req(1'b1, 1'b1, (i == 1), mb[i+1]);
      end else begin
        set_req(1'b1, 1'b0, 1'b0, 8'h00);
      end
    end
    chk("multi_cs_held", cs_err, 0);
    wait_cs(1'b0, n, ok);
    chk("multi_req0_after_release", n, 5);
    wait_done(1'b0, ok);
    chk("multi_req0_done", ok, 1);
    chk("multi_req0_rdata", rdata0, 8'h77);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // hold timeout: owner goes quiet with CS held
    hold_err = 0; extra = 0;
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 8'h01);
    wait_cs(1'b0, n, ok);
    wait_done(1'b0, ok);
    chk("hold_first_done", ok, 1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 8'h99);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 9 && adc_cs !== 1'b0) hold_err++;
      if (bme680_cs !== 1'b1) hold_err++;
      if (done0) extra++;
    end
    chk("hold_cs_kept", hold_err, 0);
    chk("hold_released", adc_cs, 1);
    chk("hold_no_extra_done", extra, 0);
    wait_cs(1'b1, n, ok);
    chk("hold_req1_grant", n, 5);
    wait_done(1'b1, ok);
    chk("hold_req1_rdata", rdata1, 8'h99);
    set_req(1'b1, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // asynchronous reset in the middle of a byte
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'hC3);
    wait_cs(1'b0, n, ok);
    repeat (10) @(negedge clk);
    chk("pre_reset_sck", sck, 1);
    #2 resetb = 1'b0;
    #1;
    chk("async_reset_pins", {sck, mosi, adc_cs, bme680_cs, done0, busy}, 6'b001100);
    set_req(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("reset_no_done", {done0, done1}, 2'b00);
    chk("reset_rdata_clear", rdata0, 8'h00);
    resetb = 1'b1;
    run_single('{r: 1'b0, wd: 8'hC3, pat_mode: 1'b0, pat: 8'h00, exp_rx: 8'hC3});

    chk("cs_exclusive_sck_gated", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
